// File: rtl/clk_meter_pkg.sv
// Shared types and defaults for the clock period meter.
package clk_meter_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input plus a history flop,
// producing single-cycle rise and fall strobes in the clkin domain.
module sync_edge_det (
  input  logic clkin,
  input  logic reset,
  input  logic sig_in,
  output logic rise_det,
  output logic fall_det
);

  logic s1, s2, s3;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise_det = s2 & ~s3;
  assign fall_det = s3 & ~s2;

endmodule

// File: rtl/clk_period_meter.sv
// Measures rise-to-rise period of sig_in in clkin cycles, with timeout.
// Optional high-time measurement when HIGH_TIME_MEAS_EN is defined.
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             timeout,
  output logic             measuring
`ifdef HIGH_TIME_MEAS_EN
  ,
  output logic [CNT_W-1:0] high_time
`endif
);

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, period_nx;
  logic             pv_nx, to_nx;
  logic             rise_det;

`ifdef HIGH_TIME_MEAS_EN
  logic             fall_det;
  logic [CNT_W-1:0] hi_cap, hi_cap_nx, high_time_nx;

  sync_edge_det u_sync (
    .clkin   (clkin),
    .reset   (reset),
    .sig_in  (sig_in),
    .rise_det(rise_det),
    .fall_det(fall_det)
  );
`else
  logic unused_fall;

  sync_edge_det u_sync (
    .clkin   (clkin),
    .reset   (reset),
    .sig_in  (sig_in),
    .rise_det(rise_det),
    .fall_det(unused_fall)
  );
`endif

  // enable=0 overrides everything; in MEASURE an edge beats the timeout.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    period_nx = period;
    pv_nx     = 1'b0;
    to_nx     = 1'b0;
    if (!enable) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nx = ARM;
          cnt_nx   = '0;
        end
        ARM: begin
          if (rise_det) begin
            state_nx = MEASURE;
            cnt_nx   = ONE;
          end
        end
        MEASURE: begin
          if (rise_det) begin
            period_nx = cnt;
            pv_nx     = 1'b1;
            cnt_nx    = ONE;
          end else if (cnt == TO_VAL) begin
            to_nx    = 1'b1;
            state_nx = ARM;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + ONE;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      period       <= period_nx;
      period_valid <= pv_nx;
      timeout      <= to_nx;
    end
  end

  assign measuring = (state == MEASURE);

`ifdef HIGH_TIME_MEAS_EN
  // cnt at the fall strobe equals cycles elapsed since the rise strobe.
  always_comb begin
    hi_cap_nx    = hi_cap;
    high_time_nx = high_time;
    if (enable && (state == MEASURE) && fall_det) hi_cap_nx = cnt;
    if (pv_nx) high_time_nx = hi_cap;
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      hi_cap    <= '0;
      high_time <= '0;
    end else begin
      hi_cap    <= hi_cap_nx;
      high_time <= high_time_nx;
    end
  end
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter (TIMEOUT_CYC=20), table-driven
// square-wave vectors plus directed multi-cycle sequences.
module tb_clk_period_meter;

  logic        clkin = 1'b0;
  logic        reset;
  logic        sig_in;
  logic        enable;
  logic [15:0] period;
  logic        period_valid;
  logic        timeout;
  logic        measuring;
`ifdef HIGH_TIME_MEAS_EN
  logic [15:0] high_time;
`endif

  clk_period_meter #(.CNT_W(16), .TIMEOUT_CYC(20)) dut (
    .clkin       (clkin),
    .reset       (reset),
    .sig_in      (sig_in),
    .enable      (enable),
    .period      (period),
    .period_valid(period_valid),
    .timeout     (timeout),
    .measuring   (measuring)
`ifdef HIGH_TIME_MEAS_EN
    ,
    .high_time   (high_time)
`endif
  );

  always #5 clkin = ~clkin;

  int nrun  = 0;
  int nfail = 0;
  int cycn  = 0;
  int hi    = 5;
  int lo    = 5;
  int ph    = 0;
  bit wave_on = 1'b0;
  int last_p  = 0;

  typedef struct {
    int          hi;
    int          lo;
    bit          expv;
    logic [15:0] exp_p;
    logic [15:0] exp_h;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nrun++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clkin);
    #1;
    cycn++;
    if (wave_on) begin
      sig_in = (ph < hi);
      ph = (ph + 1 == hi + lo) ? 0 : ph + 1;
    end
  endtask

  task automatic wait_valid(input string nm, input int bound);
    for (int i = 0; i < bound; i++) begin
      cyc();
      if (period_valid) break;
    end
    check({nm, "_seen"}, period_valid, 1);
  endtask

  task automatic run_vec(input int idx);
    int nv, nto, both, t2, t3, bound;
    vec_t v;
    v = vecs[idx];
    enable = 1'b0; wave_on = 1'b0; sig_in = 1'b0;
    repeat (4) cyc();
    hi = v.hi; lo = v.lo; ph = 0; wave_on = 1'b1; enable = 1'b1;
    nv = 0; nto = 0; both = 0; t2 = 0; t3 = 0;
    bound = 6 * (v.hi + v.lo) + 40;
    for (int i = 0; i < bound && nv < 3; i++) begin
      cyc();
      if (period_valid && timeout) both++;
      if (timeout) nto++;
      if (period_valid) begin
        nv++;
        if (nv == 2) t2 = cycn;
        if (nv == 3) t3 = cycn;
        check($sformatf("v%0d_period", idx), period, v.exp_p);
      end
    end
    check($sformatf("v%0d_both", idx), both, 0);
    if (v.expv) begin
      check($sformatf("v%0d_nvalid", idx), nv, 3);
      check($sformatf("v%0d_interval", idx), t3 - t2, v.hi + v.lo);
      check($sformatf("v%0d_timeout", idx), nto, 0);
      check($sformatf("v%0d_measuring", idx), measuring, 1);
`ifdef HIGH_TIME_MEAS_EN
      check($sformatf("v%0d_high_time", idx), high_time, v.exp_h);
`endif
      last_p = v.exp_p;
    end else begin
      check($sformatf("v%0d_nvalid", idx), nv, 0);
      check($sformatf("v%0d_timeout_seen", idx), nto > 0, 1);
      check($sformatf("v%0d_period_hold", idx), period, last_p);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{hi: 5,  lo: 5,  expv: 1'b1, exp_p: 16'd10, exp_h: 16'd5};
    vecs[1] = '{hi: 1,  lo: 1,  expv: 1'b1, exp_p: 16'd2,  exp_h: 16'd1};
    vecs[2] = '{hi: 3,  lo: 4,  expv: 1'b1, exp_p: 16'd7,  exp_h: 16'd3};
    vecs[3] = '{hi: 8,  lo: 12, expv: 1'b1, exp_p: 16'd20, exp_h: 16'd8};
    vecs[4] = '{hi: 10, lo: 11, expv: 1'b0, exp_p: 16'd0,  exp_h: 16'd0};

    // 1: reset held with sig_in toggling, then released with enable low.
    reset = 1'b1; enable = 1'b0; sig_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sig_in = ~sig_in;
      cyc();
      check("reset_outs", {period, period_valid, timeout, measuring}, 0);
    end
`ifdef HIGH_TIME_MEAS_EN
    check("reset_high_time", high_time, 0);
`endif
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sig_in = ~sig_in;
      cyc();
    end
    check("idle_outs", {period, period_valid, timeout, measuring}, 0);

    // 2: square-wave vectors, including period == TIMEOUT_CYC and one past it.
    for (int i = 0; i < 5; i++) run_vec(i);

    // 3: slow (16) then fast (6) divider; change seen on first full new period.
    enable = 1'b0; wave_on = 1'b0; sig_in = 1'b0;
    repeat (3) cyc();
    hi = 8; lo = 8; ph = 0; wave_on = 1'b1; enable = 1'b1;
    wait_valid("slow_first", 80);
    check("slow_first_period", period, 16);
    for (int i = 0; i < 20 && ph != 0; i++) cyc();
    check("switch_phase", ph, 0);
    hi = 3; lo = 3;
    wait_valid("switch_a", 40);
    check("switch_a_period", period, 16);
    wait_valid("switch_b", 40);
    check("switch_b_period", period, 6);
    wait_valid("switch_c", 40);
    check("switch_c_period", period, 6);
    last_p = 6;

    // 4: single edge then silence -> timeout 20 cycles after arming.
    enable = 1'b0; wave_on = 1'b0; sig_in = 1'b0;
    repeat (2) cyc();
    enable = 1'b1;
    repeat (3) cyc();
    sig_in = 1'b1;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      n++;
      if (n == 3) begin
        sig_in = 1'b0;
        check("to_measuring", measuring, 1);
      end
      if (timeout) break;
    end
    check("to_seen", timeout, 1);
    check("to_latency", n, 3 + 20);
    check("to_in_arm", measuring, 0);
    check("to_period_hold", period, last_p);
    check("to_no_valid", period_valid, 0);
    cyc();
    check("to_one_cycle", timeout, 0);

    // 5: enable dropped in the cycle rise_det is high.
    sig_in = 1'b1;
    repeat (3) cyc();
    sig_in = 1'b0;
    repeat (4) cyc();
    check("drop_pre_measuring", measuring, 1);
    sig_in = 1'b1;
    repeat (2) cyc();
    enable = 1'b0;
    cyc();
    check("drop_valid", period_valid, 0);
    check("drop_timeout", timeout, 0);
    check("drop_idle", measuring, 0);
    check("drop_period_hold", period, last_p);
`ifdef HIGH_TIME_MEAS_EN
    check("drop_high_time_hold", high_time, 3);
`endif
    cyc();
    check("drop_valid_late", period_valid, 0);
    sig_in = 1'b0;

    // 6: asynchronous reset in MEASURE at cnt=7, then normal re-measure.
    repeat (3) cyc();
    enable = 1'b1;
    repeat (3) cyc();
    sig_in = 1'b1;
    repeat (3) cyc();
    sig_in = 1'b0;
    check("rst_mid_measuring", measuring, 1);
    repeat (6) cyc();
    #2 reset = 1'b1;
    #1;
    check("rst_mid_outs", {period, period_valid, timeout, measuring}, 0);
`ifdef HIGH_TIME_MEAS_EN
    check("rst_mid_high_time", high_time, 0);
`endif
    repeat (2) cyc();
    reset = 1'b0;
    last_p = 0;
    run_vec(0);

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
